// File: rtl/pdp8l_xbr_pkg.sv
// Shared constants, register map and ARM access FSM states for the xbr arbiter.
package pdp8l_xbr_pkg;

  localparam int unsigned AW = 15;  // word address width (32K words)
  localparam int unsigned DW = 12;  // word data width

  localparam logic [11:0] XbrVersion = 12'h001;
  // 'X' 'B', size code 1, version
  localparam logic [31:0] XbrIdent   = {20'h58421, XbrVersion};

  localparam logic [1:0] RegIdent = 2'd0;
  localparam logic [1:0] RegAddr  = 2'd1;
  localparam logic [1:0] RegWdat  = 2'd2;
  localparam logic [1:0] RegRead  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StIssue,
    StCapt
  } arm_st_e;

  // Status word layout shared by registers 1 and 2.
  function automatic logic [31:0] stat_word(input logic busy, input logic done,
                                            input logic ovr, input logic [28:0] low);
    return {busy, done, ovr, low};
  endfunction

endpackage

// File: rtl/pdp8l_xbr_arbiter_if.sv
// ARM register port, PDP-side xbr bus and block RAM port of the xbr arbiter.
interface pdp8l_xbr_arbiter_if;
  import pdp8l_xbr_pkg::*;

  logic          armwrite;
  logic [1:0]    armraddr;
  logic [1:0]    armwaddr;
  logic [31:0]   armwdata;
  logic [31:0]   armrdata;

  logic [AW-1:0] xbraddr;
  logic [DW-1:0] xbrwdat;
  logic [DW-1:0] xbrrdat;
  logic          xbrenab;
  logic          xbrwena;

  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramwdat;
  logic [DW-1:0] ramrdat;
  logic          ramen;
  logic          ramwe;

  // Environment side: ARM core, extended-memory controller and RAM read data.
  modport master (
    output armwrite, armraddr, armwaddr, armwdata, xbraddr, xbrwdat, xbrenab, xbrwena,
           ramrdat,
    input  armrdata, xbrrdat, ramaddr, ramwdat, ramen, ramwe
  );

  // Arbiter side.
  modport slave (
    input  armwrite, armraddr, armwaddr, armwdata, xbraddr, xbrwdat, xbrenab, xbrwena,
           ramrdat,
    output armrdata, xbrrdat, ramaddr, ramwdat, ramen, ramwe
  );

endinterface

// File: rtl/pdp8l_xbr_ram.sv
// Inferred single-port 32K x 12 block RAM with a one-clock registered read.
module pdp8l_xbr_ram
  import pdp8l_xbr_pkg::*;
(
  input  logic          CLOCK,
  input  logic          ramen,
  input  logic          ramwe,
  input  logic [AW-1:0] ramaddr,
  input  logic [DW-1:0] ramwdat,
  output logic [DW-1:0] ramrdat
);

  logic [DW-1:0] mem [2**AW];

  // Write on enable+we; otherwise an enabled cycle loads the output register.
  always_ff @(posedge CLOCK) begin
    if (ramen) begin
      if (ramwe) begin
        mem[ramaddr] <= ramwdat;
      end else begin
        ramrdat <= mem[ramaddr];
      end
    end
  end

endmodule

// File: rtl/pdp8l_xbr_arbiter.sv
// PDP/ARM arbiter for the extended-memory block RAM. The PDP xbr port always wins; the
// ARM single-word port only issues in cycles with xbrenab low.
// Optional build macro PDP8L_XBR_AUTOINC_EN: post-increment the ARM address after each
// completed access, suppressible for one access by reg1 wdata[31].
module pdp8l_xbr_arbiter
  import pdp8l_xbr_pkg::*;
(
  input logic                CLOCK,
  input logic                RESET,
  pdp8l_xbr_arbiter_if.slave bus
);

  arm_st_e       state_q, state_d;
  logic [AW-1:0] addr_q, addr_pend_q;
  logic          addr_pend_vld_q;
  logic [DW-1:0] wdat_q, ardat_q;
  logic          op_we_q;
  logic          busy_q, done_q, ovr_q;
  logic [15:0]   pdpcnt_q, armwait_q;
  logic          xbrenab_q;
`ifdef PDP8L_XBR_AUTOINC_EN
  logic          noinc_q, noinc_pend_q;
`endif

  logic wr_addr, wr_start_w, wr_start_r, start, accept, arm_done;

  logic unused_wdata;
  assign unused_wdata = ^bus.armwdata[31:AW];

  assign wr_addr    = bus.armwrite && (bus.armwaddr == RegAddr);
  assign wr_start_w = bus.armwrite && (bus.armwaddr == RegWdat);
  assign wr_start_r = bus.armwrite && (bus.armwaddr == RegRead) && bus.armwdata[0];
  assign start      = wr_start_w || wr_start_r;
  assign accept     = start && !busy_q;

  // A write finishes in its issue cycle; a read finishes in the capture cycle.
  assign arm_done = (state_q == StCapt) ||
                    ((state_q == StIssue) && !bus.xbrenab && op_we_q);

  assign bus.xbrrdat = bus.ramrdat;

  // ARM access FSM state register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ARM FSM next state; a PDP enable in the issue cycle pushes the access back to PEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StPend;
      StPend:  if (!bus.xbrenab) state_d = StIssue;
      StIssue: begin
        if (bus.xbrenab) begin
          state_d = StPend;
        end else if (op_we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StCapt;
        end
      end
      StCapt:  state_d = StIdle;
    endcase
  end

  // RAM port mux: PDP first, then an issuing ARM access, otherwise idle.
  always_comb begin
    bus.ramen   = 1'b0;
    bus.ramwe   = 1'b0;
    bus.ramaddr = '0;
    bus.ramwdat = '0;
    if (!RESET) begin
      if (bus.xbrenab) begin
        bus.ramen   = 1'b1;
        bus.ramwe   = bus.xbrwena;
        bus.ramaddr = bus.xbraddr;
        bus.ramwdat = bus.xbrwdat;
      end else if (state_q == StIssue) begin
        bus.ramen   = 1'b1;
        bus.ramwe   = op_we_q;
        bus.ramaddr = addr_q;
        bus.ramwdat = wdat_q;
      end
    end
  end

  // ARM register read mux.
  always_comb begin
    bus.armrdata = '0;
    unique case (bus.armraddr)
      RegIdent: bus.armrdata = XbrIdent;
      RegAddr:  bus.armrdata = stat_word(busy_q, done_q, ovr_q, {{(29-AW){1'b0}}, addr_q});
      RegWdat:  bus.armrdata = stat_word(busy_q, done_q, ovr_q, {{(29-DW){1'b0}}, ardat_q});
      RegRead:  bus.armrdata = {pdpcnt_q, armwait_q};
    endcase
  end

  // Registers, status flags, address update and counters.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      addr_q          <= '0;
      addr_pend_q     <= '0;
      addr_pend_vld_q <= 1'b0;
      wdat_q          <= '0;
      ardat_q         <= '0;
      op_we_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      ovr_q           <= 1'b0;
      pdpcnt_q        <= '0;
      armwait_q       <= '0;
      xbrenab_q       <= 1'b0;
`ifdef PDP8L_XBR_AUTOINC_EN
      noinc_q         <= 1'b0;
      noinc_pend_q    <= 1'b0;
`endif
    end else begin
      xbrenab_q <= bus.xbrenab;
      if (bus.xbrenab && !xbrenab_q) begin
        pdpcnt_q <= pdpcnt_q + 16'd1;
      end
      if ((state_q == StPend) && bus.xbrenab && (armwait_q != 16'hFFFF)) begin
        armwait_q <= armwait_q + 16'd1;
      end

      if (accept) begin
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        op_we_q <= wr_start_w;
        if (wr_start_w) begin
          wdat_q <= bus.armwdata[DW-1:0];
        end
      end else if (start) begin
        ovr_q <= 1'b1;
      end

      // The RAM output still holds the ARM read even if the PDP is enabled now.
      if (state_q == StCapt) begin
        ardat_q <= bus.ramrdat;
      end

      if (arm_done) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        if (addr_pend_vld_q) begin
          addr_q          <= addr_pend_q;
          addr_pend_vld_q <= 1'b0;
`ifdef PDP8L_XBR_AUTOINC_EN
          noinc_q         <= noinc_pend_q;
        end else begin
          if (!noinc_q) begin
            addr_q <= addr_q + AW'(1);
          end
          noinc_q <= 1'b0;
`endif
        end
      end

      // An address write during an op is parked until that op completes.
      if (wr_addr) begin
        ovr_q <= 1'b0;
        if (busy_q && !arm_done) begin
          addr_pend_q     <= bus.armwdata[AW-1:0];
          addr_pend_vld_q <= 1'b1;
`ifdef PDP8L_XBR_AUTOINC_EN
          noinc_pend_q    <= bus.armwdata[31];
`endif
        end else begin
          addr_q <= bus.armwdata[AW-1:0];
`ifdef PDP8L_XBR_AUTOINC_EN
          noinc_q <= bus.armwdata[31];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pdp8l_xbr_arbiter.sv
// Directed self-checking bench for pdp8l_xbr_arbiter with a RAM model on its ram* port.
module tb_pdp8l_xbr_arbiter;
  import pdp8l_xbr_pkg::*;

  logic CLOCK;
  logic RESET;
  int   n_tests;
  int   n_fail;
  logic saw_ram;

  localparam logic [31:0] NoInc = 32'h8000_0000;

  pdp8l_xbr_arbiter_if bus ();

  pdp8l_xbr_arbiter dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  pdp8l_xbr_ram u_ram (
    .CLOCK   (CLOCK),
    .ramen   (bus.ramen),
    .ramwe   (bus.ramwe),
    .ramaddr (bus.ramaddr),
    .ramwdat (bus.ramwdat),
    .ramrdat (bus.ramrdat)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic arm_wr(input logic [1:0] sel, input logic [31:0] data);
    bus.armwrite = 1'b1;
    bus.armwaddr = sel;
    bus.armwdata = data;
    tick();
    bus.armwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    bus.armraddr = sel;
    #1;
    check(tag, bus.armrdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RESET        = 1'b1;
    bus.armwrite = 1'b0;
    bus.armraddr = 2'd0;
    bus.armwaddr = 2'd0;
    bus.armwdata = '0;
    bus.xbraddr  = '0;
    bus.xbrwdat  = '0;
    bus.xbrenab  = 1'b0;
    bus.xbrwena  = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state
    rd_chk("ident", 2'd0, 32'h5842_1001);
    rd_chk("rst_reg1", 2'd1, 32'h0);
    rd_chk("rst_reg2", 2'd2, 32'h0);
    rd_chk("rst_reg3", 2'd3, 32'h0);
    check("rst_ram", {bus.ramen, bus.ramwe, bus.ramaddr, bus.ramwdat}, 32'h0);

    // Uncontended ARM write of 04321 at 012345
    arm_wr(2'd1, NoInc | 32'o12345);
    rd_chk("addr_set", 2'd1, 32'h0000_14E5);
    arm_wr(2'd2, 32'o4321);
    rd_chk("busy_set", 2'd1, 32'h8000_14E5);
    check("pend_no_ram", bus.ramen, 1'b0);
    tick();
    check("wr_issue_en", {bus.ramen, bus.ramwe}, 2'b11);
    check("wr_issue_addr", bus.ramaddr, 15'o12345);
    check("wr_issue_data", bus.ramwdat, 12'o4321);
    tick();
    rd_chk("wr_done_2clk", 2'd1, 32'h4000_14E5);

    // Uncontended ARM read back
    arm_wr(2'd1, NoInc | 32'o12345);
    arm_wr(2'd3, 32'd1);
    rd_chk("rd_busy", 2'd2, 32'h8000_0000);
    tick();
    check("rd_issue", {bus.ramen, bus.ramwe}, 2'b10);
    tick();
    rd_chk("rd_capt_busy", 2'd2, 32'h8000_0000);
    tick();
    rd_chk("rd_done_3clk", 2'd2, 32'h4000_08D1);

    // ARM write held off by 5 clocks of PDP enable
    arm_wr(2'd1, NoInc | 32'o100);
    arm_wr(2'd2, 32'o7070);
    bus.xbrenab = 1'b1;
    bus.xbrwena = 1'b0;
    bus.xbraddr = 15'o12345;
    #1;
    check("pdp_en", {bus.ramen, bus.ramwe}, 2'b10);
    check("pdp_addr", bus.ramaddr, 15'o12345);
    tick();
    check("pdp_rd_data", bus.xbrrdat, 12'o4321);
    repeat (4) tick();
    check("pdp_still_owns", bus.ramaddr, 15'o12345);
    bus.xbrenab = 1'b0;
    #1;
    check("arm_waits_drop", bus.ramen, 1'b0);
    tick();
    check("arm_after_pdp", {bus.ramen, bus.ramwe}, 2'b11);
    check("arm_after_pdp_addr", bus.ramaddr, 15'o100);
    check("arm_after_pdp_data", bus.ramwdat, 12'o7070);
    tick();
    rd_chk("counters", 2'd3, 32'h0001_0005);

    // Start while busy is dropped and sets sticky ovr
    arm_wr(2'd1, NoInc | 32'o100);
    arm_wr(2'd2, 32'o1111);
    arm_wr(2'd2, 32'o2222);
    check("ovr_keeps_data", bus.ramwdat, 12'o1111);
    rd_chk("ovr_set", 2'd1, 32'hA000_0040);
    tick();
    rd_chk("ovr_sticky", 2'd1, 32'h6000_0040);
    arm_wr(2'd1, NoInc | 32'o200);
    rd_chk("ovr_clear", 2'd1, 32'h4000_0080);

    // Address write while busy takes effect after the op completes
    arm_wr(2'd2, 32'o5555);
    arm_wr(2'd1, NoInc | 32'o300);
    rd_chk("pend_addr_hold", 2'd1, 32'h8000_0080);
    check("pend_issue_addr", bus.ramaddr, 15'o200);
    tick();
    rd_chk("pend_addr_apply", 2'd1, 32'h4000_00C0);

    // Reset while PEND aborts the access
    arm_wr(2'd1, NoInc | 32'o400);
    bus.xbrenab = 1'b1;
    bus.xbraddr = 15'o12345;
    arm_wr(2'd2, 32'o6666);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus.xbrenab = 1'b0;
    rd_chk("rst_abort_busy", 2'd1, 32'h0);
    rd_chk("rst_abort_reg2", 2'd2, 32'h0);
    rd_chk("rst_counters", 2'd3, 32'h0);
    saw_ram = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ramen || bus.ramwe) saw_ram = 1'b1;
    end
    check("rst_no_ram", saw_ram, 1'b0);

`ifdef PDP8L_XBR_AUTOINC_EN
    // Post-increment wraps 077777 -> 0 -> 1
    arm_wr(2'd1, 32'o77777);
    rd_chk("inc_start", 2'd1, 32'h0000_7FFF);
    arm_wr(2'd2, 32'o1234);
    repeat (2) tick();
    rd_chk("inc_wrap", 2'd1, 32'h4000_0000);
    arm_wr(2'd2, 32'o4567);
    repeat (2) tick();
    rd_chk("inc_next", 2'd1, 32'h4000_0001);
    bus.xbrenab = 1'b1;
    bus.xbraddr = 15'o77777;
    tick();
    check("inc_data_hi", bus.xbrrdat, 12'o1234);
    bus.xbraddr = 15'o0;
    tick();
    check("inc_data_lo", bus.xbrrdat, 12'o4567);
    bus.xbrenab = 1'b0;
`else
    // Address is unchanged by accesses; wdata[31] has no effect
    arm_wr(2'd1, NoInc | 32'o77777);
    rd_chk("no_inc_start", 2'd1, 32'h0000_7FFF);
    arm_wr(2'd2, 32'o1234);
    repeat (2) tick();
    rd_chk("no_inc", 2'd1, 32'h4000_7FFF);
    bus.xbrenab = 1'b1;
    bus.xbraddr = 15'o77777;
    tick();
    check("no_inc_data", bus.xbrrdat, 12'o1234);
    bus.xbrenab = 1'b0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
